// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O responder: PortOut register, synchronized PortIn, and an
// event FIFO that logs every synchronized PortIn change for software to drain.
module mmio_port_responder #(
  parameter logic [31:0] IO_BASE     = 32'h1001_0100,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [7:0]  PortIn,
  output logic [31:0] ReadData,
  output logic        IOSelect,
  output logic [31:0] PortOut
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] OFF_OUT  = 2'd0;
  localparam logic [1:0] OFF_IN   = 2'd1;
  localparam logic [1:0] OFF_STAT = 2'd2;
  localparam logic [1:0] OFF_EVT  = 2'd3;

  logic [SYNC_STAGES-1:0][7:0] r_sync;
  logic [7:0]                  r_prev;
  logic [FIFO_DEPTH-1:0][7:0]  r_mem;
  logic [AW-1:0]               r_wp, r_rp;
  logic [CW-1:0]               r_count;
  logic                        r_ovf;
  logic [31:0]                 r_port_out;

  logic        w_hit, w_wr, w_empty, w_full, w_change, w_pop, w_push, w_unused;
  logic [1:0]  w_off;
  logic [7:0]  w_sync_q;
  logic [31:0] w_status;

  assign w_hit    = (Address[31:4] == IO_BASE[31:4]);
  assign w_off    = Address[3:2];
  assign w_wr     = MemWrite & w_hit;
  assign w_unused = ^Address[1:0];

  assign w_sync_q = r_sync[SYNC_STAGES-1];
  assign w_change = (w_sync_q != r_prev);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_pop    = MemRead & w_hit & (w_off == OFF_EVT) & ~w_empty;
  // A full FIFO still accepts a push when the same edge pops the head.
  assign w_push   = w_change & (~w_full | w_pop);

  assign w_status = {16'b0, 8'(r_count), 5'b0, r_ovf, w_full, ~w_empty};

  assign IOSelect = w_hit;
  assign PortOut  = r_port_out;

  always_comb begin
    ReadData = '0;
    if (MemRead && w_hit) begin
      case (w_off)
        OFF_OUT:  ReadData = r_port_out;
        OFF_IN:   ReadData = {24'b0, w_sync_q};
        OFF_STAT: ReadData = w_status;
        OFF_EVT:  ReadData = w_empty ? 32'b0 : {24'b0, r_mem[r_rp]};
        default:  ReadData = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync     <= '0;
      r_prev     <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_port_out <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], PortIn};
      r_prev <= w_sync_q;

      if (w_wr && w_off == OFF_OUT)
        r_port_out <= WriteData;

      // Set takes priority over a same-edge W1C clear.
      if (w_change && w_full && !w_pop)
        r_ovf <= 1'b1;
      else if (w_wr && w_off == OFF_STAT && WriteData[2])
        r_ovf <= 1'b0;

      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_push)
      r_mem[r_wp] <= w_sync_q;
  end
endmodule

// File: tb/tb_mmio_port_responder.sv
// Bench for mmio_port_responder: directed scenarios plus random bus traffic,
// checked every cycle against a queue-based behavioural model.
module tb_mmio_port_responder;
  localparam logic [31:0] BASE  = 32'h1001_0100;
  localparam int          DEPTH = 4;
  localparam int          SYNC  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Address = '0, WriteData = '0;
  logic        MemWrite = 1'b0, MemRead = 1'b0;
  logic [7:0]  PortIn = '0;
  logic [31:0] ReadData, PortOut;
  logic        IOSelect;

  mmio_port_responder #(.IO_BASE(BASE), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .PortIn(PortIn),
    .ReadData(ReadData), .IOSelect(IOSelect), .PortOut(PortOut)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: pipe holds the last SYNC samples of PortIn, oldest first.
  logic [7:0]  m_pipe[$];
  logic [7:0]  m_fifo[$];
  logic [7:0]  m_prev;
  logic        m_ovf;
  logic [31:0] m_out;

  task automatic m_reset();
    m_pipe.delete();
    for (int i = 0; i < SYNC; i++) m_pipe.push_back(8'h00);
    m_fifo.delete();
    m_prev = 8'h00;
    m_ovf  = 1'b0;
    m_out  = '0;
  endtask

  function automatic logic m_hit();
    return Address[31:4] == BASE[31:4];
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[15:8] = 8'(m_fifo.size());
    s[2] = m_ovf;
    s[1] = (m_fifo.size() == DEPTH);
    s[0] = (m_fifo.size() != 0);
    return s;
  endfunction

  function automatic logic [31:0] exp_rd();
    logic [31:0] r;
    r = '0;
    if (MemRead && m_hit()) begin
      case (Address[3:2])
        2'd0: r = m_out;
        2'd1: r = {24'b0, m_pipe[0]};
        2'd2: r = m_status();
        default: r = (m_fifo.size() != 0) ? {24'b0, m_fifo[0]} : 32'b0;
      endcase
    end
    return r;
  endfunction

  task automatic m_edge();
    logic [7:0] sq;
    logic       pop;
    int         pre;
    sq  = m_pipe[0];
    pre = m_fifo.size();
    pop = MemRead && m_hit() && Address[3:2] == 2'd3 && pre != 0;
    if (MemWrite && m_hit() && Address[3:2] == 2'd0) m_out = WriteData;
    if (MemWrite && m_hit() && Address[3:2] == 2'd2 && WriteData[2]) m_ovf = 1'b0;
    if (pop) void'(m_fifo.pop_front());
    if (sq != m_prev) begin
      if (pre == DEPTH && !pop) m_ovf = 1'b1;
      else m_fifo.push_back(sq);
    end
    m_prev = sq;
    m_pipe.push_back(PortIn);
    void'(m_pipe.pop_front());
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) m_reset();
      else m_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("ReadData", ReadData, exp_rd());
      chk("IOSelect", {31'b0, IOSelect}, {31'b0, m_hit()});
      chk("PortOut", PortOut, m_out);
    end
  end

  task automatic go(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus(logic [31:0] a, logic [31:0] d, logic we, logic re);
    Address = a; WriteData = d; MemWrite = we; MemRead = re;
  endtask

  task automatic idle();
    bus(32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // One load, checked mid-cycle, then one edge with the bus released.
  task automatic rd(string name, logic [31:0] a, logic [31:0] exp);
    bus(a, 32'h0, 1'b0, 1'b1);
    #1;
    chk(name, ReadData, exp);
    go();
    idle();
  endtask

  task automatic steps(logic [7:0] v0, logic [7:0] v1, logic [7:0] v2,
                       logic [7:0] v3, logic [7:0] v4, int n);
    logic [7:0] v[5];
    v = '{v0, v1, v2, v3, v4};
    for (int i = 0; i < n; i++) begin
      PortIn = v[i];
      go(2);
    end
    go(4);
  endtask

  initial begin
    go(1);
    rd("reset STATUS", BASE + 32'h8, 32'h0);
    chk("reset PortOut", PortOut, 32'h0);
    reset = 1'b1;

    // 1: store and load PORT_OUT
    bus(BASE, 32'hDEADBEEF, 1'b1, 1'b0);
    go();
    idle();
    chk("T1 PortOut", PortOut, 32'hDEADBEEF);
    bus(BASE, 32'h0, 1'b0, 1'b1);
    #1;
    chk("T1 IOSelect", {31'b0, IOSelect}, 32'h1);
    chk("T1 ReadData", ReadData, 32'hDEADBEEF);
    go();
    idle();

    // 2: single PortIn step through the synchronizer
    PortIn = 8'h5A;
    go(2);
    rd("T2 PORT_IN", BASE + 32'h4, 32'h5A);
    rd("T2 STATUS", BASE + 32'h8, 32'h0101);
    rd("T2 EVENT", BASE + 32'hC, 32'h5A);
    rd("T2 STATUS after pop", BASE + 32'h8, 32'h0);

    // 3: five events into a four-deep FIFO
    steps(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 5);
    rd("T3 STATUS", BASE + 32'h8, 32'h0407);
    rd("T3 EVENT0", BASE + 32'hC, 32'h11);
    rd("T3 EVENT1", BASE + 32'hC, 32'h22);
    rd("T3 EVENT2", BASE + 32'hC, 32'h33);
    rd("T3 EVENT3", BASE + 32'hC, 32'h44);
    rd("T3 STATUS drained", BASE + 32'h8, 32'h0004);
    bus(BASE + 32'h8, 32'h4, 1'b1, 1'b0);
    go();
    idle();
    rd("T3 STATUS cleared", BASE + 32'h8, 32'h0);

    // 4: pop and push on the same edge while full
    steps(8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 4);
    rd("T4 STATUS full", BASE + 32'h8, 32'h0403);
    PortIn = 8'h77;
    go(2);
    rd("T4 EVENT with push", BASE + 32'hC, 32'h01);
    rd("T4 STATUS", BASE + 32'h8, 32'h0403);
    rd("T4 EVENT1", BASE + 32'hC, 32'h02);
    rd("T4 EVENT2", BASE + 32'hC, 32'h03);
    rd("T4 EVENT3", BASE + 32'hC, 32'h04);
    rd("T4 EVENT4", BASE + 32'hC, 32'h77);

    // 5: empty EVENT read, out-of-window access, read+write same cycle
    rd("T5 EVENT empty", BASE + 32'hC, 32'h0);
    rd("T5 STATUS", BASE + 32'h8, 32'h0);
    bus(BASE + 32'h10, 32'h12345678, 1'b1, 1'b1);
    #1;
    chk("T5 IOSelect out", {31'b0, IOSelect}, 32'h0);
    chk("T5 ReadData out", ReadData, 32'h0);
    go();
    idle();
    chk("T5 PortOut kept", PortOut, 32'hDEADBEEF);
    bus(BASE, 32'hCAFEF00D, 1'b1, 1'b1);
    #1;
    chk("T5 RW old value", ReadData, 32'hDEADBEEF);
    go();
    idle();
    rd("T5 RW new value", BASE, 32'hCAFEF00D);

    // 6: asynchronous reset with events queued
    steps(8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 3);
    bus(BASE, 32'hFF, 1'b1, 1'b0);
    go();
    idle();
    rd("T6 STATUS queued", BASE + 32'h8, 32'h0301);
    bus(BASE + 32'h8, 32'h0, 1'b0, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    chk("T6 async PortOut", PortOut, 32'h0);
    chk("T6 async STATUS", ReadData, 32'h0);
    idle();
    go(2);
    reset = 1'b1;
    go(3);
    rd("T6 post-reset STATUS", BASE + 32'h8, 32'h0101);
    rd("T6 post-reset EVENT", BASE + 32'hC, 32'hA3);

    // Random traffic, checked each cycle by the compare process
    repeat (800) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = BASE + 32'($urandom_range(0, 15));
      bus(a, $urandom, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 3) == 0) PortIn = 8'($urandom);
      go();
    end
    idle();
    go(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
